img_bram_arb: RTL and testbench
===============================

IMG_BRAM_ARB -- requirements
Module: img_bram_arb

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 17, meaning the image BRAM address width.
REQ-002 The module SHALL have parameter DATA_W, default 24, meaning the pixel width in bits.
REQ-003 The module SHALL have parameter RD_LAT, default 1, legal range 1..3, meaning the BRAM read latency in cycles.
REQ-004 The module SHALL have parameter STARVE_MAX, default 16, legal range 1..255, meaning the writer wait limit in cycles.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The module SHALL have port rd_req, input, 1 bit: video reader requests a read.
REQ-008 The module SHALL have port rd_addr, input, ADDR_W bits: read address.
REQ-009 The module SHALL have port rd_gnt, output, 1 bit: read issued this cycle.
REQ-010 The module SHALL have port rd_data, output, DATA_W bits: returned pixel.
REQ-011 The module SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-012 The module SHALL have port wr_req, input, 1 bit: loader requests a write.
REQ-013 The module SHALL have port wr_addr, input, ADDR_W bits: write address.
REQ-014 The module SHALL have port wr_data, input, DATA_W bits: write pixel.
REQ-015 The module SHALL have port wr_gnt, output, 1 bit: write committed this cycle.
REQ-016 The module SHALL have BRAM ports: bram_en (output, 1), bram_we (output, 1), bram_addr (output, ADDR_W), bram_din (output, DATA_W) and bram_dout (input, DATA_W).
REQ-017 The module SHALL have port stall_cnt, output, 16 bits: count of cycles with wr_req high and wr_gnt low.

Function
REQ-018 The arbiter SHALL issue at most one grant per cycle; rd_gnt and wr_gnt SHALL never both be high.
REQ-019 Grants SHALL be combinational from the current requests and registered state:
- rd_gnt = rd_req & ~force_wr
- wr_gnt = wr_req & (~rd_req | force_wr)
REQ-020 The BRAM outputs SHALL be driven as follows:
- bram_en = rd_gnt | wr_gnt
- bram_we = wr_gnt
- bram_addr = wr_addr when wr_gnt, otherwise rd_addr
- bram_din = wr_data
REQ-021 rd_valid SHALL be high exactly RD_LAT cycles after each rd_gnt, with rd_data = bram_dout in that cycle; back-to-back grants SHALL give back-to-back valids, in order.
REQ-022 The ownership FSM SHALL have states IDLE, READ, WRITE and FORCED, updated each cycle as follows:
- no grant -> IDLE
- rd_gnt -> READ
- wr_gnt with force_wr -> FORCED
- any other wr_gnt -> WRITE
REQ-023 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-024 stall_cnt SHALL saturate at 16'hFFFF and not wrap.
REQ-025 A request deasserted while waiting SHALL not be remembered: there are no queued grants.

Reset
REQ-026 While rst is high, the module SHALL set the FSM to IDLE, clear the rd_valid pipeline, clear the starve counter and clear stall_cnt.
REQ-027 While rst is high, rd_gnt, wr_gnt, bram_en and bram_we SHALL be forced to 0.
REQ-028 Reads in flight when rst asserts SHALL be discarded, with no rd_valid produced afterwards.
REQ-029 rd_data SHALL be 0 under reset.

Configuration
REQ-030 With IMG_ARB_STARVE_EN defined, an 8-bit starve_cnt SHALL behave as follows:
- increments when wr_req & ~wr_gnt, saturating at STARVE_MAX
- clears on wr_gnt or when wr_req is low
- force_wr = (starve_cnt == STARVE_MAX), so exactly one write is granted over a pending read and starve_cnt then clears
REQ-031 Without IMG_ARB_STARVE_EN, force_wr SHALL be constant 0, reads SHALL have strict priority, the FORCED state SHALL be unreachable, and starve_cnt SHALL not exist.

Structure
REQ-032 Package img_bram_pkg SHALL hold the ADDR_W and DATA_W defaults, the FSM state enum typedef (2 bits) and STALL_CNT_W = 16.
REQ-033 Sub-module img_rd_vpipe SHALL implement the RD_LAT-deep valid shift register with synchronous clear; arbitration, the FSM and the counters SHALL stay in img_bram_arb.

Verification
REQ-034 The bench SHALL drive rd_req only, for 10 cycles, addr 0..9 with RD_LAT=1, and check 10 consecutive rd_valid with data matching the preload, each one cycle after its grant.
REQ-035 The bench SHALL drive rd_req=0 and wr_req=1 at addr 5 with data 24'hABCDEF, then rd_req at addr 5 the next cycle, and check rd_data=24'hABCDEF.
REQ-036 With the macro defined and STARVE_MAX=4, the bench SHALL hold rd_req and wr_req high and check one wr_gnt on the 5th cycle, the FSM in FORCED, then READ resuming and a repeat every 5 cycles.
REQ-037 Without the macro, the bench SHALL hold both requests high for 70000 cycles and check wr_gnt never asserts and stall_cnt=16'hFFFF.
REQ-038 With RD_LAT=2, the bench SHALL issue 3 reads then assert rst in the cycle after the last grant, and check no rd_valid afterwards and all outputs at reset values.
REQ-039 The bench SHALL run random rd_req/wr_req for 10000 cycles and check rd_gnt & wr_gnt is never 1 and bram_en equals rd_gnt|wr_gnt.

Source files
------------

// File: rtl/img_bram_pkg.sv
// Shared defaults and ownership-state encoding for the image BRAM arbiter.
package img_bram_pkg;
  localparam int ADDR_W_DEF  = 17;
  localparam int DATA_W_DEF  = 24;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FORCED = 2'd3
  } arb_state_e;
endpackage

// File: rtl/img_rd_vpipe.sv
// Read-valid delay line: a grant reappears STAGES cycles later; sync clear drops reads in flight.
module img_rd_vpipe #(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  output logic out_vld
);
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      for (int s = 2; s <= STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  assign out_vld = vld_pipe[STAGES];
endmodule

// File: rtl/img_bram_arb.sv
// Single-port image BRAM arbiter: video reader has priority over the loader.
// Define IMG_ARB_STARVE_EN to force one write through after STARVE_MAX waiting cycles.
module img_bram_arb
  import img_bram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_req,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_gnt,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
  input  logic                   wr_req,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_gnt,
  output logic                   bram_en,
  output logic                   bram_we,
  output logic [ADDR_W-1:0]      bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  input  logic [DATA_W-1:0]      bram_dout,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  if (RD_LAT < 1 || RD_LAT > 3 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
    $error("img_bram_arb: RD_LAT or STARVE_MAX out of range");
  end

  arb_state_e state_q, state_d;
  logic       force_wr;
  logic       pipe_vld;

`ifdef IMG_ARB_STARVE_EN
  logic [7:0] starve_cnt;

  assign force_wr = (starve_cnt == 8'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (rst || !wr_req || wr_gnt) starve_cnt <= '0;
    else if (!force_wr)           starve_cnt <= starve_cnt + 8'd1;
  end
`else
  assign force_wr = 1'b0;
`endif

  assign rd_gnt = ~rst & rd_req & ~force_wr;
  assign wr_gnt = ~rst & wr_req & (~rd_req | force_wr);

  assign bram_en   = rd_gnt | wr_gnt;
  assign bram_we   = wr_gnt;
  assign bram_addr = wr_gnt ? wr_addr : rd_addr;
  assign bram_din  = wr_data;

  img_rd_vpipe #(.STAGES(RD_LAT)) u_vpipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rd_gnt),
    .out_vld (pipe_vld)
  );

  // Gate with rst so a read landing in the first reset cycle is dropped too.
  assign rd_valid = pipe_vld & ~rst;
  assign rd_data  = rd_valid ? bram_dout : '0;

  always_ff @(posedge clk) begin
    if (rst)                                   stall_cnt <= '0;
    else if (wr_req && !wr_gnt && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (rd_gnt)      state_d = ST_READ;
    else if (wr_gnt) state_d = force_wr ? ST_FORCED : ST_WRITE;
  end

  // Ownership state is a debug/probe view; nothing downstream consumes it.
  logic unused_state;
  assign unused_state = ^state_q;
endmodule

// File: tb/tb_img_bram_arb.sv
// Randomized bench for img_bram_arb against a cycle-level behavioural model (honours IMG_ARB_STARVE_EN).
module tb_img_bram_arb;
  import img_bram_pkg::*;

  localparam int AW   = 17;
  localparam int DW   = 24;
  localparam int SMAX = 4;
`ifdef IMG_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rd_req, wr_req, rd_gnt, wr_gnt, rd_valid, bram_en, bram_we;
  logic [AW-1:0] rd_addr, wr_addr, bram_addr;
  logic [DW-1:0] rd_data, wr_data, bram_din, bram_dout;
  logic [15:0]   stall_cnt;

  logic          rst2, rd_req2, wr_req2, rd_gnt2, wr_gnt2, rd_valid2, bram_en2, bram_we2;
  logic [AW-1:0] rd_addr2, wr_addr2, bram_addr2;
  logic [DW-1:0] rd_data2, wr_data2, bram_din2, bram_dout2, b2_s1, b2_s2;
  logic [15:0]   stall_cnt2;

  img_bram_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_gnt(wr_gnt), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout), .stall_cnt(stall_cnt)
  );

  img_bram_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .STARVE_MAX(16)) dut2 (
    .clk(clk), .rst(rst2), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_gnt(rd_gnt2),
    .rd_data(rd_data2), .rd_valid(rd_valid2), .wr_req(wr_req2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_gnt(wr_gnt2), .bram_en(bram_en2), .bram_we(bram_we2),
    .bram_addr(bram_addr2), .bram_din(bram_din2), .bram_dout(bram_dout2), .stall_cnt(stall_cnt2)
  );

  // Single-port BRAM, one-cycle read latency, write-first not needed (ports are exclusive).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else         bram_dout <= mem[bram_addr];
    end
  end

  // Two-cycle BRAM for dut2; contents are a fixed function of address.
  always @(posedge clk) begin
    if (bram_en2) b2_s1 <= DW'(bram_addr2) ^ 24'h5A0000;
    b2_s2 <= b2_s1;
  end
  assign bram_dout2 = b2_s2;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  typedef struct { int due; logic [DW-1:0] data; } rdexp_t;
  rdexp_t        exp_q[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            cycle, waited, stall_m, valid_seen, wr_seen;
  arb_state_e    st_m;
  logic          obs_wr;
  logic [DW-1:0] last_rd_data;

  task automatic step(input logic rr, input logic [AW-1:0] ra, input logic wr,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic e_force, e_rd, e_wr;
    rd_req = rr; rd_addr = ra; wr_req = wr; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    // Reader wins unless the writer has already waited the full limit.
    e_force = STARVE_ON && (waited == SMAX);
    e_rd    = rr && !e_force;
    e_wr    = wr && (!rr || e_force);
    chk("rd_gnt", 32'(rd_gnt), 32'(e_rd));
    chk("wr_gnt", 32'(wr_gnt), 32'(e_wr));
    chk("gnt_excl", 32'(rd_gnt & wr_gnt), 32'd0);
    chk("bram_en", 32'(bram_en), 32'(e_rd | e_wr));
    chk("bram_we", 32'(bram_we), 32'(e_wr));
    chk("bram_addr", 32'(bram_addr), 32'(e_wr ? wa : ra));
    chk("bram_din", 32'(bram_din), 32'(wd));
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    chk("state", 32'(dut.state_q), 32'(st_m));
    if (exp_q.size() != 0 && exp_q[0].due == cycle) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(exp_q[0].data));
      if (rd_valid) begin valid_seen++; last_rd_data = rd_data; end
      void'(exp_q.pop_front());
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
    end
    obs_wr = wr_gnt;
    if (wr_gnt) wr_seen++;
    if (e_wr) ref_mem[wa] = wd;
    if (e_rd) exp_q.push_back('{cycle + 1, ref_mem[ra]});
    st_m    = e_rd ? ST_READ : (e_wr ? (e_force ? ST_FORCED : ST_WRITE) : ST_IDLE);
    stall_m = (wr && !e_wr && stall_m < 65535) ? stall_m + 1 : stall_m;
    waited  = (!wr || e_wr) ? 0 : ((waited < SMAX) ? waited + 1 : waited);
    @(posedge clk); #1;
    cycle++;
  endtask

  task automatic do_reset();
    rst = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_rd_gnt", 32'(rd_gnt), 32'd0);
      chk("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      chk("rst_bram_en", 32'(bram_en), 32'd0);
      chk("rst_bram_we", 32'(bram_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      @(posedge clk); #1;
      cycle++;
    end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    exp_q.delete();
    waited = 0; stall_m = 0; st_m = ST_IDLE;
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, w0;
    rst2 = 1'b1; rd_req2 = 1'b0; wr_req2 = 1'b0; rd_addr2 = '0; wr_addr2 = '0; wr_data2 = '0;
    cycle = 0; valid_seen = 0; wr_seen = 0; last_rd_data = '0; obs_wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    do_reset();

    // Ten back-to-back reads of the preload
    v0 = valid_seen;
    for (int i = 0; i < 10; i++) step(1'b1, AW'(i), 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    chk("burst_valid_count", 32'(valid_seen - v0), 32'd10);

    // Read right after a write to the same address
    step(1'b0, '0, 1'b1, AW'(5), 24'hABCDEF);
    step(1'b1, AW'(5), 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, '0, '0);
    chk("raw_data", 32'(last_rd_data), 32'hABCDEF);

`ifdef IMG_ARB_STARVE_EN
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step(1'b1, AW'(k % 32), 1'b1, AW'((k + 7) % 32), DW'($urandom));
      chk("starve_wr", 32'(obs_wr), 32'((k % 5) == 4));
      chk("starve_state", 32'(dut.state_q), 32'(((k % 5) == 4) ? ST_FORCED : ST_READ));
    end
`endif

    for (int n = 0; n < 10000; n++)
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 31)),
           $urandom_range(0, 1) == 1, AW'($urandom_range(0, 31)), DW'($urandom));

`ifndef IMG_ARB_STARVE_EN
    w0 = wr_seen;
    for (int n = 0; n < 70000; n++) step(1'b1, AW'(n % 32), 1'b1, AW'(n % 32), DW'(n));
    chk("strict_no_wr", 32'(wr_seen - w0), 32'd0);
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
`else
    w0 = 0;
`endif

    // RD_LAT=2: three reads, reset the cycle after the last grant
    rst2 = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      rd_req2 = (k != 5); rd_addr2 = AW'(k); wr_req2 = (k == 3 || k == 4);
      rst2 = (k == 3 || k == 4);
      @(negedge clk);
      chk("l2_rd_gnt", 32'(rd_gnt2), 32'(k < 3));
      chk("l2_wr_gnt", 32'(wr_gnt2), 32'd0);
      chk("l2_bram_en", 32'(bram_en2), 32'(k < 3));
      chk("l2_bram_we", 32'(bram_we2), 32'd0);
      chk("l2_rd_valid", 32'(rd_valid2), 32'(k == 2));
      chk("l2_rd_data", 32'(rd_data2), (k == 2) ? 32'h5A0000 : 32'd0);
      if (k >= 4) begin
        chk("l2_stall_cnt", 32'(stall_cnt2), 32'd0);
        chk("l2_state", 32'(dut2.state_q), 32'(ST_IDLE));
      end
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
